// File: rtl/gpio_input_filter_if.sv
// Pad, control and filtered-output signals of the GPIO input filter.
// The master drives pads and controls; the slave (the filter) drives the outputs.
interface gpio_input_filter_if #(
    parameter int PDATA_SIZE    = 32,
    parameter int CNT_SIZE      = 8,
    parameter int PRESCALE_SIZE = 16
);
    logic [PDATA_SIZE-1:0]    pad_i;
    logic [PDATA_SIZE-1:0]    filt_ena;
    logic [PRESCALE_SIZE-1:0] prescale;
    logic [CNT_SIZE-1:0]      threshold;
    logic [PDATA_SIZE-1:0]    gpio_o;
    logic [PDATA_SIZE-1:0]    rise_o;
    logic [PDATA_SIZE-1:0]    fall_o;

    modport master (
        output pad_i, filt_ena, prescale, threshold,
        input  gpio_o, rise_o, fall_o
    );

    modport slave (
        input  pad_i, filt_ena, prescale, threshold,
        output gpio_o, rise_o, fall_o
    );
endinterface

// File: rtl/gpio_input_filter.sv
// Per-bit pad synchroniser plus tick-based debounce filter with rise/fall pulses.
// Every output is registered; pad_i reaches the filter only through the sync chain.
module gpio_input_filter #(
    parameter int PDATA_SIZE    = 32,
    parameter int CNT_SIZE      = 8,
    parameter int PRESCALE_SIZE = 16,
    parameter int SYNC_STAGES   = 2
) (
    input logic               PCLK,
    input logic               PRESET,
    gpio_input_filter_if.slave bus
);

    logic [PDATA_SIZE-1:0]    sync_p [SYNC_STAGES];
    logic [PDATA_SIZE-1:0]    sync_w;
    logic [PRESCALE_SIZE-1:0] pcnt;
    logic                     tick;
    logic [CNT_SIZE-1:0]      eff_thr;
    logic [CNT_SIZE-1:0]      cnt_q [PDATA_SIZE];
    logic [CNT_SIZE-1:0]      cnt_d [PDATA_SIZE];
    logic [PDATA_SIZE-1:0]    gpio_q;
    logic [PDATA_SIZE-1:0]    gpio_d;
    logic [PDATA_SIZE-1:0]    rise_q;
    logic [PDATA_SIZE-1:0]    fall_q;

    // One extra bit so cnt+1 can never wrap before it is compared.
    function automatic logic [CNT_SIZE:0] cnt_inc(input logic [CNT_SIZE-1:0] c);
        return {1'b0, c} + {{CNT_SIZE{1'b0}}, 1'b1};
    endfunction

    function automatic logic [CNT_SIZE-1:0] thr_floor(input logic [CNT_SIZE-1:0] t);
        return (t == '0) ? {{(CNT_SIZE-1){1'b0}}, 1'b1} : t;
    endfunction

    assign sync_w  = sync_p[SYNC_STAGES-1];
    assign eff_thr = thr_floor(bus.threshold);
    // >= rather than == so lowering prescale below pcnt wraps on the next cycle.
    assign tick    = (pcnt >= bus.prescale);

    always_comb begin
        gpio_d = gpio_q;
        for (int n = 0; n < PDATA_SIZE; n++) begin
            cnt_d[n] = cnt_q[n];
            if (!bus.filt_ena[n]) begin
                gpio_d[n] = sync_w[n];
                cnt_d[n]  = '0;
            end else if (sync_w[n] == gpio_q[n]) begin
                cnt_d[n] = '0;
            end else if (tick) begin
                if (cnt_inc(cnt_q[n]) >= {1'b0, eff_thr}) begin
                    gpio_d[n] = sync_w[n];
                    cnt_d[n]  = '0;
                end else begin
                    cnt_d[n] = cnt_q[n] + {{(CNT_SIZE-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
            for (int n = 0; n < PDATA_SIZE; n++) cnt_q[n] <= '0;
            pcnt   <= '0;
            gpio_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            // Stage boundary: pad -> synchroniser chain
            sync_p[0] <= bus.pad_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
            pcnt <= tick ? '0 : pcnt + {{(PRESCALE_SIZE-1){1'b0}}, 1'b1};
            // Stage boundary: synchronised level -> filtered level and edge pulses
            for (int n = 0; n < PDATA_SIZE; n++) cnt_q[n] <= cnt_d[n];
            gpio_q <= gpio_d;
            rise_q <= gpio_d & ~gpio_q;
            fall_q <= ~gpio_d & gpio_q;
        end
    end

    assign bus.gpio_o = gpio_q;
    assign bus.rise_o = rise_q;
    assign bus.fall_o = fall_q;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Scoreboard bench for gpio_input_filter: stimulus queues expected edge events,
// a negedge monitor pops one entry for every cycle the DUT shows a rise/fall pulse.
module tb_gpio_input_filter;

    typedef struct {
        string       name;
        int          lo;
        int          hi;
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] gpio;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    gpio_input_filter_if #(.PDATA_SIZE(32), .CNT_SIZE(8), .PRESCALE_SIZE(16)) bus ();

    gpio_input_filter #(
        .PDATA_SIZE(32), .CNT_SIZE(8), .PRESCALE_SIZE(16), .SYNC_STAGES(2)
    ) dut (
        .PCLK  (clk),
        .PRESET(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input int lo, input int hi,
                        input logic [31:0] rise, input logic [31:0] fall, input logic [31:0] gpio);
        exp_t e;
        e.name = nm; e.lo = lo; e.hi = hi; e.rise = rise; e.fall = fall; e.gpio = gpio;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int n, output int r);
        rst = 1'b1;
        step(n);
        r   = cyc;
        rst = 1'b0;
    endtask

    task automatic drain(input string nm, input int n);
        step(n);
        chk({nm, "_pending"}, sb.size(), 0);
    endtask

    // Monitor: every pulse cycle must match the oldest queued event.
    always @(negedge clk) begin
        if (!rst && ((bus.rise_o | bus.fall_o) != '0)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: cycle %0d rise %h fall %h gpio %h",
                         cyc, bus.rise_o, bus.fall_o, bus.gpio_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                if (cyc < e.lo || cyc > e.hi) begin
                    n_fail++;
                    $display("FAIL %s_time: got cycle %0d expected %0d..%0d", e.name, cyc, e.lo, e.hi);
                end
                chk({e.name, "_rise"}, bus.rise_o, e.rise);
                chk({e.name, "_fall"}, bus.fall_o, e.fall);
                chk({e.name, "_gpio"}, bus.gpio_o, e.gpio);
            end
        end
    end

    initial begin
        int r, t;
        bus.pad_i     = '0;
        bus.filt_ena  = '0;
        bus.prescale  = '0;
        bus.threshold = '0;

        // Test 1: pads high through reset, bypass mode
        bus.pad_i = '1;
        rst = 1'b1;
        step(3);
        chk("t1_reset_gpio", bus.gpio_o, 32'h0);
        chk("t1_reset_rise", bus.rise_o, 32'h0);
        chk("t1_reset_fall", bus.fall_o, 32'h0);
        r = cyc;
        push("t1_bypass", r + 3, r + 3, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
        rst = 1'b0;
        step(2);
        chk("t1_gpio_before", bus.gpio_o, 32'h0);
        drain("t1", 6);
        chk("t1_gpio_after", bus.gpio_o, 32'hFFFF_FFFF);

        // Test 2: threshold 4, prescale 0, step on bit 0 up then down
        bus.pad_i     = '0;
        bus.filt_ena  = '1;
        bus.prescale  = 16'd0;
        bus.threshold = 8'd4;
        do_reset(3, r);
        step(3);
        t = cyc;
        push("t2_rise", t + 6, t + 6, 32'h1, 32'h0, 32'h1);
        bus.pad_i[0] = 1'b1;
        drain("t2_rise", 10);
        t = cyc;
        push("t2_fall", t + 6, t + 6, 32'h0, 32'h1, 32'h0);
        bus.pad_i[0] = 1'b0;
        drain("t2_fall", 10);

        // Test 3: 3-cycle glitch is rejected
        bus.pad_i[0] = 1'b1;
        step(3);
        bus.pad_i[0] = 1'b0;
        drain("t3", 10);
        chk("t3_gpio", bus.gpio_o, 32'h0);

        // Test 4a: prescale 9, threshold 3, step on bit 5 with unknown tick phase
        bus.prescale  = 16'd9;
        bus.threshold = 8'd3;
        do_reset(2, r);
        step(4);
        t = cyc;
        push("t4_prescaled", t + 23, t + 32, 32'h20, 32'h0, 32'h20);
        bus.pad_i[5] = 1'b1;
        drain("t4_prescaled", 36);

        // Test 4b: prescale lowered below pcnt=7 ticks on the next edge
        bus.pad_i     = 32'h40;
        bus.prescale  = 16'd9;
        bus.threshold = 8'd1;
        do_reset(2, r);
        step(7);
        bus.prescale = 16'd2;
        push("t4_lowered", r + 8, r + 8, 32'h40, 32'h0, 32'h40);
        drain("t4_lowered", 6);

        // Test 5a: threshold 0 acts as 1
        bus.pad_i     = '0;
        bus.prescale  = 16'd0;
        bus.threshold = 8'd0;
        do_reset(2, r);
        step(3);
        t = cyc;
        push("t5_thr0", t + 3, t + 3, 32'h2, 32'h0, 32'h2);
        bus.pad_i[1] = 1'b1;
        drain("t5_thr0", 6);

        // Test 5b: threshold 255, no counter wrap
        bus.threshold = 8'd255;
        t = cyc;
        push("t5_thr255", t + 257, t + 257, 32'h4, 32'h0, 32'h6);
        bus.pad_i[2] = 1'b1;
        step(200);
        chk("t5_thr255_mid", bus.gpio_o, 32'h2);
        drain("t5_thr255", 62);

        // Test 6: reset mid-count discards partial count on bit 3
        bus.pad_i     = '0;
        bus.threshold = 8'd4;
        do_reset(2, r);
        step(3);
        t = cyc;
        bus.pad_i[3] = 1'b1;
        step(4);
        do_reset(2, r);
        push("t6_restart", r + 6, r + 6, 32'h8, 32'h0, 32'h8);
        step(1);
        chk("t6_gpio_after_reset", bus.gpio_o, 32'h0);
        step(4);
        chk("t6_gpio_r5", bus.gpio_o, 32'h0);
        drain("t6_restart", 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
